pwm_meas: RTL and testbench
===========================

Name: pwm_meas

Overview:
- Receive-side counterpart of the PWM stimulus source used in the emulation benches.
- Takes a fixed-point analog model output (svreal-format signed integer with a shared exponent) and recovers a digital square wave with a hysteresis comparator.
- Measures period and high time in emulator clock cycles and delivers each result over a valid/ready interface to a host or probe.
- Sits after the analog model (e.g. a filter output) so benches can check waveform timing in hardware.

Parameters:
- WIDTH, 18, bit width of in_val, th_hi and th_lo (svreal significand width).
- COUNT_W, 16, width of the period and high-time results.
- OVR_W, 8, width of the overrun counter.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst_n  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable.
- in_val  in  WIDTH  signed fixed-point analog sample.
- th_hi  in  WIDTH  signed rising threshold, same exponent as in_val.
- th_lo  in  WIDTH  signed falling threshold; th_lo <= th_hi required.
- in_dig  out  1  recovered digital waveform.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts the result.
- meas_period  out  COUNT_W  cycles between consecutive in_dig rising edges.
- meas_high  out  COUNT_W  cycles in_dig stayed high within that period.
- meas_sat  out  1  one or both fields saturated.
- ovr_cnt  out  OVR_W  dropped results, saturating.

Behaviour:
- Reset: one clock, emu_clk. Reset is asynchronous, active-low on emu_rst_n. All outputs and counters clear to 0; state = ARM.
- Comparator: signed compare, registered.
  - in_val > th_hi sets in_dig = 1 next cycle.
  - in_val < th_lo sets in_dig = 0 next cycle.
  - Otherwise in_dig holds.
  - Equal to a threshold counts as inside the band.
  - The comparator runs regardless of en.
- Edges: rise/fall are in_dig transitions detected on the registered value (edge visible in the cycle in_dig changes).
- States:
  - ARM: wait for a rise, then clear cnt_p to 1 and go to HIGH.
  - HIGH: cnt_p increments each cycle. On fall, latch hi = cnt_p and go to LOW.
  - LOW: cnt_p increments each cycle. On rise, the result is period = cnt_p, high = hi. Restart cnt_p = 1 and go to HIGH.
  - The first rise after ARM produces no result.
- Counters: cnt_p saturates at 2^COUNT_W-1 and sets an internal sat flag. The flag clears on restart and is published as meas_sat. A saturated result is still published.
- Latency: meas_valid rises the cycle after the rise that completes a period.
- Handshake:
  - Transfer occurs when meas_valid & meas_ready; meas_valid drops next cycle unless a new result loads.
  - Result fields are stable while meas_valid = 1 and meas_ready = 0.
  - New result while valid and not ready: the new result is discarded and ovr_cnt increments, saturating at 2^OVR_W-1.
  - New result in the same cycle as a transfer: the new result loads and meas_valid stays 1; no overrun.
- en = 0: state is forced to ARM and cnt_p/hi clear. A pending result stays held until transferred. Re-enabling mid-high waits for the next rise.
- Reset mid-operation: immediate clear; any pending result is lost.

Decomposition:
- Package pwm_meas_pkg: state enum (ARM, HIGH, LOW) and a COUNT_MAX constant function of COUNT_W.
- Sub-module hyst_comp: registered hysteresis comparator (WIDTH parameter; in_val, th_hi, th_lo -> in_dig).
- Counter, FSM and output register stay in pwm_meas.

Test Plan (WIDTH=18, COUNT_W=16, th_hi=+100, th_lo=-100 unless stated):
- Clean measurement:
  - Stimulus: square wave ±1000, 50 cycles high / 50 low, meas_ready = 1.
  - Response: first result 2 rises after enable; period = 100, high = 50, meas_sat = 0, ovr_cnt = 0.
- Hysteresis:
  - Stimulus: hold in_dig high, then toggle in_val between +60 and -60 every cycle for 40 cycles.
  - Response: in_dig stays 1, no result emitted. Then -1000 sets in_dig to 0 exactly 1 cycle later.
- Saturation:
  - Stimulus: COUNT_W = 8; 300 cycles high, 20 cycles low.
  - Response: meas_high = 255, meas_period = 255, meas_sat = 1. Next normal 20/20 period gives 40/20 with meas_sat = 0.
- Backpressure:
  - Stimulus: meas_ready = 0 for 3 periods of 40/20.
  - Response: meas_valid high with the first result (40/20) held stable; ovr_cnt = 2.
  - With meas_ready pulsed on the cycle a new result completes: meas_valid stays 1, fields update, ovr_cnt unchanged.
- Enable and reset:
  - Stimulus: deassert en mid-high, reassert mid-low.
  - Response: no result until 2 rises later.
  - Stimulus: assert emu_rst_n = 0 asynchronously mid-period.
  - Response: all outputs 0 immediately, without waiting for an emu_clk edge.
- Equality edge:
  - Stimulus: in_val = +100 exactly.
  - Response: no rise. At +101, in_dig = 1 next cycle.

Source files
------------

// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM period/high-time measurement block.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // All-ones value of a w-bit counter (w < 32).
  function automatic logic [31:0] count_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/hyst_comp.sv
// Registered hysteresis comparator: signed compare against a rising and a falling threshold.
module hyst_comp #(
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_val_i,
  input  logic [WIDTH-1:0] th_hi_i,
  input  logic [WIDTH-1:0] th_lo_i,
  output logic             dig_o
);

  logic dig_q, dig_d;

  // Values equal to either threshold sit inside the band and hold the output.
  always_comb begin
    dig_d = dig_q;
    if ($signed(in_val_i) > $signed(th_hi_i))      dig_d = 1'b1;
    else if ($signed(in_val_i) < $signed(th_lo_i)) dig_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dig_q <= 1'b0;
    else         dig_q <= dig_d;
  end

  assign dig_o = dig_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM receiver: recovers a square wave from a fixed-point sample stream and
// measures period / high time between rising edges, delivered over valid/ready.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int COUNT_W = 16,
  parameter int OVR_W   = 8
) (
  input  logic               emu_clk,
  input  logic               emu_rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   in_val,
  input  logic [WIDTH-1:0]   th_hi,
  input  logic [WIDTH-1:0]   th_lo,
  output logic               in_dig,
  output logic               meas_valid,
  input  logic               meas_ready,
  output logic [COUNT_W-1:0] meas_period,
  output logic [COUNT_W-1:0] meas_high,
  output logic               meas_sat,
  output logic [OVR_W-1:0]   ovr_cnt
);

  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(count_max(COUNT_W));

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, cnt_inc;
  logic               sat_q, sat_d, inc_sat;
  logic               dig_prev_q, rise, fall, load;
  logic               vld_q, vld_d, osat_q, osat_d;
  logic [COUNT_W-1:0] per_q, per_d, high_q, high_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;

  hyst_comp #(.WIDTH(WIDTH)) u_comp (
    .clk_i    (emu_clk),
    .rst_ni   (emu_rst_n),
    .in_val_i (in_val),
    .th_hi_i  (th_hi),
    .th_lo_i  (th_lo),
    .dig_o    (in_dig)
  );

  assign rise = in_dig & ~dig_prev_q;
  assign fall = ~in_dig & dig_prev_q;

  always_comb begin
    cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + COUNT_W'(1);
    inc_sat = (cnt_q == CMAX);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    sat_d   = sat_q;
    load    = 1'b0;
    case (state_q)
      ARM: if (rise) begin
        cnt_d   = COUNT_W'(1);
        sat_d   = 1'b0;
        state_d = HIGH;
      end
      HIGH: begin
        cnt_d = cnt_inc;
        sat_d = sat_q | inc_sat;
        if (fall) begin
          hi_d    = cnt_q;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          load    = 1'b1;
          cnt_d   = COUNT_W'(1);
          sat_d   = 1'b0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_inc;
          sat_d = sat_q | inc_sat;
        end
      end
      default: state_d = ARM;
    endcase
    // Disabled: drop back to ARM; a pending result is left untouched below.
    if (!en) begin
      state_d = ARM;
      cnt_d   = '0;
      hi_d    = '0;
      sat_d   = 1'b0;
      load    = 1'b0;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    per_d  = per_q;
    high_d = high_q;
    osat_d = osat_q;
    ovr_d  = ovr_q;
    if (vld_q && meas_ready) vld_d = 1'b0;
    if (load) begin
      if (!vld_q || meas_ready) begin
        vld_d  = 1'b1;
        per_d  = cnt_q;
        high_d = hi_q;
        osat_d = sat_q;
      end else if (ovr_q != '1) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q    <= ARM;
      cnt_q      <= '0;
      hi_q       <= '0;
      sat_q      <= 1'b0;
      dig_prev_q <= 1'b0;
      vld_q      <= 1'b0;
      per_q      <= '0;
      high_q     <= '0;
      osat_q     <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      sat_q      <= sat_d;
      dig_prev_q <= in_dig;
      vld_q      <= vld_d;
      per_q      <= per_d;
      high_q     <= high_d;
      osat_q     <= osat_d;
      ovr_q      <= ovr_d;
    end
  end

  assign meas_valid  = vld_q;
  assign meas_period = per_q;
  assign meas_high   = high_q;
  assign meas_sat    = osat_q;
  assign ovr_cnt     = ovr_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas; a COUNT_W=8 copy shares the stimulus for saturation.
module tb_pwm_meas;

  logic        emu_clk = 1'b0;
  logic        emu_rst_n, en, meas_ready;
  logic [17:0] in_val, th_hi, th_lo;
  logic        in_dig, meas_valid, meas_sat;
  logic [15:0] meas_period, meas_high;
  logic [7:0]  ovr_cnt;
  logic        s_dig, s_valid, s_sat;
  logic [7:0]  s_period, s_high, s_ovr;

  int checks = 0;
  int errors = 0;
  int nres   = 0;
  int n0;

  always #5 emu_clk = ~emu_clk;

  assign th_hi = 18'sd100;
  assign th_lo = -18'sd100;

  pwm_meas #(.WIDTH(18), .COUNT_W(16), .OVR_W(8)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .en(en), .in_val(in_val),
    .th_hi(th_hi), .th_lo(th_lo), .in_dig(in_dig), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .meas_period(meas_period), .meas_high(meas_high),
    .meas_sat(meas_sat), .ovr_cnt(ovr_cnt)
  );

  pwm_meas #(.WIDTH(18), .COUNT_W(8), .OVR_W(8)) dut_sat (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .en(en), .in_val(in_val),
    .th_hi(th_hi), .th_lo(th_lo), .in_dig(s_dig), .meas_valid(s_valid),
    .meas_ready(meas_ready), .meas_period(s_period), .meas_high(s_high),
    .meas_sat(s_sat), .ovr_cnt(s_ovr)
  );

  // Counts transfers of the main instance.
  always @(posedge emu_clk) if (meas_valid && meas_ready) nres++;

  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  task automatic set_v(input int v);
    in_val = v[17:0];
  endtask

  task automatic drive(input int v, input int n);
    set_v(v);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    emu_rst_n = 1'b0; en = 1'b0; meas_ready = 1'b0; set_v(-1000);
    tick(); tick();
    emu_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    emu_rst_n = 1'b0; en = 1'b0; meas_ready = 1'b0; set_v(1000);
    tick(); tick();
    checks++;
    if ({in_dig, meas_valid, meas_sat, meas_period, meas_high, ovr_cnt} !== 43'd0) begin
      errors++; $display("FAIL reset_outputs got valid=%0d dig=%0d per=%0d hi=%0d ovr=%0d exp all 0",
                         meas_valid, in_dig, meas_period, meas_high, ovr_cnt);
    end
    do_reset();
  endtask

  task automatic test_clean();
    do_reset(); en = 1'b1; meas_ready = 1'b1; n0 = nres;
    drive(-1000, 10); drive(1000, 50); drive(-1000, 50);
    checks++;
    if (nres - n0 !== 0) begin errors++; $display("FAIL clean_no_first_result got %0d exp 0", nres - n0); end
    set_v(1000); tick();
    checks++;
    if ({in_dig, meas_valid} !== 2'b10) begin
      errors++; $display("FAIL clean_latency got dig=%0d valid=%0d exp dig=1 valid=0", in_dig, meas_valid);
    end
    tick();
    checks++;
    if ({meas_valid, meas_period, meas_high, meas_sat, ovr_cnt} !== {1'b1, 16'd100, 16'd50, 1'b0, 8'd0}) begin
      errors++; $display("FAIL clean_result1 got v=%0d p=%0d h=%0d sat=%0d ovr=%0d exp v=1 p=100 h=50 sat=0 ovr=0",
                         meas_valid, meas_period, meas_high, meas_sat, ovr_cnt);
    end
    drive(1000, 48); drive(-1000, 50); set_v(1000); tick(); tick();
    checks++;
    if ({meas_valid, meas_period, meas_high} !== {1'b1, 16'd100, 16'd50}) begin
      errors++; $display("FAIL clean_result2 got v=%0d p=%0d h=%0d exp v=1 p=100 h=50", meas_valid, meas_period, meas_high);
    end
    tick();
    checks++;
    if (nres - n0 !== 2 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL clean_count got n=%0d v=%0d exp n=2 v=0", nres - n0, meas_valid);
    end
  endtask

  task automatic test_hysteresis();
    int bad;
    do_reset(); en = 1'b1; meas_ready = 1'b1; n0 = nres; bad = 0;
    drive(1000, 3);
    for (int i = 0; i < 40; i++) begin
      set_v((i % 2) ? -60 : 60); tick();
      checks++;
      if (in_dig !== 1'b1) begin errors++; bad++; if (bad < 4) $display("FAIL hyst_hold cyc %0d got %0d exp 1", i, in_dig); end
    end
    checks++;
    if (nres - n0 !== 0 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL hyst_no_result got n=%0d v=%0d exp 0", nres - n0, meas_valid);
    end
    set_v(-1000); tick();
    checks++;
    if (in_dig !== 1'b0) begin errors++; $display("FAIL hyst_fall got %0d exp 0", in_dig); end
  endtask

  task automatic test_equality();
    do_reset(); en = 1'b1;
    drive(100, 5);
    checks++;
    if (in_dig !== 1'b0) begin errors++; $display("FAIL eq_hi_inside got %0d exp 0", in_dig); end
    set_v(101); tick();
    checks++;
    if (in_dig !== 1'b1) begin errors++; $display("FAIL eq_hi_plus1 got %0d exp 1", in_dig); end
    drive(-100, 5);
    checks++;
    if (in_dig !== 1'b1) begin errors++; $display("FAIL eq_lo_inside got %0d exp 1", in_dig); end
    set_v(-101); tick();
    checks++;
    if (in_dig !== 1'b0) begin errors++; $display("FAIL eq_lo_minus1 got %0d exp 0", in_dig); end
  endtask

  task automatic test_saturation();
    do_reset(); en = 1'b1; meas_ready = 1'b1;
    drive(-1000, 10); drive(1000, 300); drive(-1000, 20); set_v(1000); tick(); tick();
    checks++;
    if ({s_valid, s_period, s_high, s_sat} !== {1'b1, 8'd255, 8'd255, 1'b1}) begin
      errors++; $display("FAIL sat_result got v=%0d p=%0d h=%0d sat=%0d exp v=1 p=255 h=255 sat=1",
                         s_valid, s_period, s_high, s_sat);
    end
    drive(1000, 18); drive(-1000, 20); set_v(1000); tick(); tick();
    checks++;
    if ({s_valid, s_period, s_high, s_sat} !== {1'b1, 8'd40, 8'd20, 1'b0}) begin
      errors++; $display("FAIL sat_recover got v=%0d p=%0d h=%0d sat=%0d exp v=1 p=40 h=20 sat=0",
                         s_valid, s_period, s_high, s_sat);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); en = 1'b1; meas_ready = 1'b0;
    drive(-1000, 10); drive(1000, 20); drive(-1000, 20); set_v(1000); tick(); tick();
    checks++;
    if ({meas_valid, meas_period, meas_high, ovr_cnt} !== {1'b1, 16'd40, 16'd20, 8'd0}) begin
      errors++; $display("FAIL bp_first got v=%0d p=%0d h=%0d ovr=%0d exp v=1 p=40 h=20 ovr=0",
                         meas_valid, meas_period, meas_high, ovr_cnt);
    end
    // Two more periods of 50/30 are dropped while the first stays held.
    drive(1000, 28); drive(-1000, 20); drive(1000, 30); drive(-1000, 20); drive(1000, 5);
    checks++;
    if ({meas_valid, meas_period, meas_high, ovr_cnt} !== {1'b1, 16'd40, 16'd20, 8'd2}) begin
      errors++; $display("FAIL bp_held got v=%0d p=%0d h=%0d ovr=%0d exp v=1 p=40 h=20 ovr=2",
                         meas_valid, meas_period, meas_high, ovr_cnt);
    end
    drive(1000, 25); drive(-1000, 20); set_v(1000); tick();
    meas_ready = 1'b1; tick(); meas_ready = 1'b0;
    checks++;
    if ({meas_valid, meas_period, meas_high, ovr_cnt} !== {1'b1, 16'd50, 16'd30, 8'd2}) begin
      errors++; $display("FAIL bp_same_cycle got v=%0d p=%0d h=%0d ovr=%0d exp v=1 p=50 h=30 ovr=2",
                         meas_valid, meas_period, meas_high, ovr_cnt);
    end
    tick();
    checks++;
    if ({meas_valid, meas_period} !== {1'b1, 16'd50}) begin
      errors++; $display("FAIL bp_hold2 got v=%0d p=%0d exp v=1 p=50", meas_valid, meas_period);
    end
    meas_ready = 1'b1; tick(); meas_ready = 1'b0;
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0d exp 0", meas_valid); end
  endtask

  task automatic test_enable();
    do_reset(); en = 1'b1; meas_ready = 1'b1; n0 = nres;
    drive(-1000, 10); drive(1000, 10);
    en = 1'b0; drive(1000, 10); drive(-1000, 10);
    en = 1'b1; drive(-1000, 10); drive(1000, 20);
    checks++;
    if (nres - n0 !== 0 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL en_no_result got n=%0d v=%0d exp 0", nres - n0, meas_valid);
    end
    drive(-1000, 20); set_v(1000); tick(); tick();
    checks++;
    if ({meas_valid, meas_period, meas_high} !== {1'b1, 16'd40, 16'd20}) begin
      errors++; $display("FAIL en_result got v=%0d p=%0d h=%0d exp v=1 p=40 h=20", meas_valid, meas_period, meas_high);
    end
  endtask

  task automatic test_async_reset();
    do_reset(); en = 1'b1; meas_ready = 1'b0;
    drive(-1000, 10); drive(1000, 20); drive(-1000, 20); drive(1000, 20); drive(-1000, 20); drive(1000, 5);
    checks++;
    if ({in_dig, meas_valid, ovr_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL arst_pre got dig=%0d v=%0d ovr=%0d exp 1 1 1", in_dig, meas_valid, ovr_cnt);
    end
    #3 emu_rst_n = 1'b0;
    #1;
    checks++;
    if ({in_dig, meas_valid, meas_sat, meas_period, meas_high, ovr_cnt} !== 43'd0) begin
      errors++; $display("FAIL arst_clear got dig=%0d v=%0d p=%0d h=%0d ovr=%0d exp all 0",
                         in_dig, meas_valid, meas_period, meas_high, ovr_cnt);
    end
    tick(); emu_rst_n = 1'b1; tick();
  endtask

  initial begin
    emu_rst_n = 1'b0; en = 1'b0; meas_ready = 1'b0; in_val = '0;
    test_reset();
    test_clean();
    test_hysteresis();
    test_equality();
    test_saturation();
    test_backpressure();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
